// File: rtl/clk_div_prog.sv
// Programmable clock-enable / divided-clock generator: Tick strobe every D cycles,
// 50%-duty ClkOut of period 2*D, and a wrapping Tick counter. Divisor changes land on period boundaries.
module clk_div_prog #(
    parameter int unsigned CNT_W = 27,
    parameter int unsigned DIV0  = 100000000,
    parameter int unsigned DIV1  = 50000000,
    parameter int unsigned DIV2  = 25000000,
    parameter int unsigned EVT_W = 8
) (
    input  logic             Clk_i,
    input  logic             Rst_i,
    input  logic             En_i,
    input  logic [1:0]       Sel_i,
    input  logic             LoadDiv_i,
    input  logic [CNT_W-1:0] DivIn_i,
    output logic             ClkOut_o,
    output logic             Tick_o,
    output logic             Pending_o,
    output logic [CNT_W-1:0] ActDiv_o,
    output logic [EVT_W-1:0] EvtCnt_o
);

    localparam logic [CNT_W-1:0] DIV0_T = CNT_W'(DIV0);
    localparam logic [CNT_W-1:0] DIV1_T = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0] DIV2_T = CNT_W'(DIV2);

    // A zero divisor is promoted to 1 so ActDiv-1 can never underflow.
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
        return (x == '0) ? CNT_W'(1) : x;
    endfunction

    logic [CNT_W-1:0] divCnt_q, divCnt_d;
    logic [CNT_W-1:0] actDiv_q, actDiv_d;
    logic [CNT_W-1:0] custom_q, custom_d;
    logic [EVT_W-1:0] evtCnt_q, evtCnt_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] req;
    logic             terminal;

    always_comb begin
        req = custom_q;
        case (Sel_i)
            2'd0:    req = sat(DIV0_T);
            2'd1:    req = sat(DIV1_T);
            2'd2:    req = sat(DIV2_T);
            default: req = custom_q;
        endcase
    end

    assign terminal = (divCnt_q == (actDiv_q - CNT_W'(1)));

    // The request is only adopted at a terminal count or while paused, always with the count at zero.
    always_comb begin
        divCnt_d = divCnt_q;
        actDiv_d = actDiv_q;
        custom_d = custom_q;
        evtCnt_d = evtCnt_q;
        clkOut_d = clkOut_q;
        tick_d   = 1'b0;
        if (LoadDiv_i) begin
            custom_d = sat(DivIn_i);
        end
        if (!En_i) begin
            actDiv_d = req;
            divCnt_d = '0;
        end else if (terminal) begin
            divCnt_d = '0;
            tick_d   = 1'b1;
            clkOut_d = ~clkOut_q;
            evtCnt_d = evtCnt_q + EVT_W'(1);
            actDiv_d = req;
        end else begin
            divCnt_d = divCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            divCnt_q <= '0;
            actDiv_q <= sat(DIV0_T);
            custom_q <= sat(DIV0_T);
            evtCnt_q <= '0;
            clkOut_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            actDiv_q <= actDiv_d;
            custom_q <= custom_d;
            evtCnt_q <= evtCnt_d;
            clkOut_q <= clkOut_d;
            tick_q   <= tick_d;
        end
    end

    assign ClkOut_o  = clkOut_q;
    assign Tick_o    = tick_q;
    assign Pending_o = (req != actDiv_q);
    assign ActDiv_o  = actDiv_q;
    assign EvtCnt_o  = evtCnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with small divisors (DIV0=4, DIV1=2, DIV2=1, 4-bit event counter).
module tb_clk_div_prog;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [1:0] Sel;
    logic       LoadDiv;
    logic [7:0] DivIn;
    logic       ClkOut;
    logic       Tick;
    logic       Pending;
    logic [7:0] ActDiv;
    logic [3:0] EvtCnt;

    int compared   = 0;
    int mismatched = 0;

    clk_div_prog #(
        .CNT_W(8), .DIV0(4), .DIV1(2), .DIV2(1), .EVT_W(4)
    ) dut (
        .Clk_i    (Clk),
        .Rst_i    (Rst),
        .En_i     (En),
        .Sel_i    (Sel),
        .LoadDiv_i(LoadDiv),
        .DivIn_i  (DivIn),
        .ClkOut_o (ClkOut),
        .Tick_o   (Tick),
        .Pending_o(Pending),
        .ActDiv_o (ActDiv),
        .EvtCnt_o (EvtCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, then settle before any combinational check.
    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] sel,
                                 input logic load, input logic [7:0] divIn);
        Rst     = rst;
        En      = en;
        Sel     = sel;
        LoadDiv = load;
        DivIn   = divIn;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] expEvt;
    logic       expClk;

    initial begin
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 8'd0);
        stepCycle();
        checkOutput("rst_tick", Tick, 0);
        checkOutput("rst_clk", ClkOut, 0);
        checkOutput("rst_evt", EvtCnt, 0);
        checkOutput("rst_act", ActDiv, 4);
        checkOutput("rst_pend", Pending, 0);

        // Divide by 4: ticks on cycles 4,8,..,24; ClkOut high for cycles 4..7, 12..15, 20..23.
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 8'd0);
        for (int n = 1; n <= 24; n++) begin
            stepCycle();
            checkOutput($sformatf("d4_tick_%0d", n), Tick, (n % 4 == 0) ? 1 : 0);
            checkOutput($sformatf("d4_clk_%0d", n), ClkOut, ((n / 4) % 2 == 1) ? 1 : 0);
        end
        checkOutput("d4_evt", EvtCnt, 6);
        checkOutput("d4_pend", Pending, 0);
        checkOutput("d4_act", ActDiv, 4);

        // Switch to DIV1 two cycles into a period; the period still ends at 4.
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 8'd0);
        checkOutput("sel1_pend_a", Pending, 1);
        stepCycle();
        checkOutput("sel1_pend_b", Pending, 1);
        checkOutput("sel1_tick_27", Tick, 0);
        checkOutput("sel1_act_old", ActDiv, 4);
        stepCycle();
        checkOutput("sel1_tick_28", Tick, 1);
        checkOutput("sel1_act_new", ActDiv, 2);
        checkOutput("sel1_pend_c", Pending, 0);
        checkOutput("sel1_clk_28", ClkOut, 1);
        checkOutput("sel1_evt_28", EvtCnt, 7);
        for (int n = 29; n <= 32; n++) begin
            stepCycle();
            checkOutput($sformatf("d2_tick_%0d", n), Tick, (n % 2 == 0) ? 1 : 0);
        end
        checkOutput("d2_clk_32", ClkOut, 1);
        checkOutput("d2_evt_32", EvtCnt, 9);

        // Custom divisor 0 saturates to 1.
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 8'd0);
        checkOutput("cust_pend_a", Pending, 1);
        stepCycle();
        checkOutput("cust_tick_33", Tick, 0);
        checkOutput("cust_act_33", ActDiv, 2);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 8'd0);
        checkOutput("cust_pend_b", Pending, 1);
        stepCycle();
        checkOutput("cust_tick_34", Tick, 1);
        checkOutput("cust_act_34", ActDiv, 1);
        checkOutput("cust_clk_34", ClkOut, 0);
        checkOutput("cust_evt_34", EvtCnt, 10);
        checkOutput("cust_pend_c", Pending, 0);
        for (int n = 35; n <= 38; n++) begin
            stepCycle();
            checkOutput($sformatf("d1_tick_%0d", n), Tick, 1);
            checkOutput($sformatf("d1_clk_%0d", n), ClkOut, (n % 2 == 1) ? 1 : 0);
        end
        checkOutput("d1_evt_38", EvtCnt, 14);

        // Load 6 coincident with a terminal count: old custom value (1) is adopted first.
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 8'd6);
        stepCycle();
        checkOutput("ld6_tick_39", Tick, 1);
        checkOutput("ld6_act_39", ActDiv, 1);
        checkOutput("ld6_evt_39", EvtCnt, 15);
        checkOutput("ld6_pend_39", Pending, 1);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 8'd0);
        stepCycle();
        checkOutput("ld6_tick_40", Tick, 1);
        checkOutput("ld6_act_40", ActDiv, 6);
        checkOutput("ld6_evt_40", EvtCnt, 0);
        checkOutput("ld6_pend_40", Pending, 0);
        for (int n = 41; n <= 52; n++) begin
            stepCycle();
            checkOutput($sformatf("d6_tick_%0d", n), Tick, (n == 46 || n == 52) ? 1 : 0);
        end
        checkOutput("d6_clk_52", ClkOut, 0);
        checkOutput("d6_evt_52", EvtCnt, 2);

        // Pause mid-period; change to DIV2 while paused.
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 8'd0);
        for (int p = 55; p <= 64; p++) begin
            if (p == 60) begin
                applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 8'd0);
                checkOutput("pause_pend", Pending, 1);
            end
            stepCycle();
            checkOutput($sformatf("pause_tick_%0d", p), Tick, 0);
            checkOutput($sformatf("pause_clk_%0d", p), ClkOut, 0);
            checkOutput($sformatf("pause_evt_%0d", p), EvtCnt, 2);
            if (p == 55) checkOutput("pause_act_55", ActDiv, 6);
            if (p == 60) begin
                checkOutput("pause_act_60", ActDiv, 1);
                checkOutput("pause_pend_60", Pending, 0);
            end
        end
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 8'd0);
        stepCycle();
        checkOutput("resume_tick", Tick, 1);
        checkOutput("resume_clk", ClkOut, 1);
        checkOutput("resume_evt", EvtCnt, 3);

        // 17 more ticks: event counter passes 15 -> 0 -> 1 on its way to 4.
        expEvt = 4'd3;
        expClk = 1'b1;
        for (int k = 0; k < 17; k++) begin
            stepCycle();
            expEvt = expEvt + 4'd1;
            expClk = ~expClk;
            checkOutput($sformatf("wrap_tick_%0d", k), Tick, 1);
            checkOutput($sformatf("wrap_evt_%0d", k), EvtCnt, expEvt);
            checkOutput($sformatf("wrap_clk_%0d", k), ClkOut, expClk);
        end
        checkOutput("wrap_evt_end", EvtCnt, 4);

        // Reset mid-period with ClkOut high and Sel=3; reset beats a simultaneous load.
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 8'd0);
        stepCycle();
        checkOutput("pre_act_83", ActDiv, 6);
        checkOutput("pre_evt_83", EvtCnt, 5);
        stepCycle();
        stepCycle();
        checkOutput("pre_clk_85", ClkOut, 1);
        checkOutput("pre_tick_85", Tick, 0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 8'd9);
        stepCycle();
        checkOutput("mrst_clk", ClkOut, 0);
        checkOutput("mrst_tick", Tick, 0);
        checkOutput("mrst_evt", EvtCnt, 0);
        checkOutput("mrst_act", ActDiv, 4);
        checkOutput("mrst_pend", Pending, 0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 8'd0);
        for (int n = 87; n <= 90; n++) begin
            stepCycle();
            checkOutput($sformatf("post_tick_%0d", n), Tick, (n == 90) ? 1 : 0);
        end
        checkOutput("post_act", ActDiv, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
